i2c_target_regfile: RTL and testbench

//  I2C target (slave) with a byte-wide register file; the responder counterpart to the sequencer's I2C

---
 rtl/i2c_target_pkg.sv | 21 ++
 rtl/i2c_target_regfile_if.sv | 10 +
 rtl/i2c_line_sync.sv | 53 +++++
 rtl/i2c_target_regfile.sv | 197 +++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_MACK,
        ST_IGNORE
    } state_e;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam int   BYTE_BITS = 8;

endpackage

// File: rtl/i2c_target_regfile_if.sv
// I2C pad-side signals: the target uses the slave modport, a bus model the master modport.
interface i2c_target_regfile_if;
    logic i2c_scl_i;
    logic i2c_sda_i;
    logic i2c_sda_o;
    logic i2c_sda_t;

    modport slave  (input  i2c_scl_i, input  i2c_sda_i, output i2c_sda_o, output i2c_sda_t);
    modport master (output i2c_scl_i, output i2c_sda_i, input  i2c_sda_o, input  i2c_sda_t);
endinterface

// File: rtl/i2c_line_sync.sv
// Per-line 2-FF synchronizer, optional 3-sample majority filter, and edge pulses.
// Filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic meta_q, sync_q, prev_q;
    logic filt;

    // Lines idle high, so everything resets to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic hist1_q, hist2_q, filt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
            filt_q  <= 1'b1;
        end else begin
            hist1_q <= sync_q;
            hist2_q <= hist1_q;
            filt_q  <= (sync_q & hist1_q) | (sync_q & hist2_q) | (hist1_q & hist2_q);
        end
    end
    assign filt = filt_q;
`else
    assign filt = sync_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) prev_q <= 1'b1;
        else       prev_q <= filt;
    end

    assign level_o = filt;
    assign rise_o  = filt & ~prev_q;
    assign fall_o  = ~filt & prev_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte register file and an auto-incrementing pointer.
// Optional input glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regfile
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         REG_DEPTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    i2c_target_regfile_if.slave  bus,
    input  logic                 usr_we_i,
    input  logic [7:0]           usr_addr_i,
    input  logic [7:0]           usr_wdata_i,
    output logic [7:0]           usr_rdata_o,
    output logic                 wr_valid_o,
    output logic [7:0]           wr_addr_o,
    output logic [7:0]           wr_data_o,
    output logic                 busy_o
);
    localparam int IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_line_sync u_scl_sync (.clk_i(clk_i), .rst_i(rst_i), .line_i(bus.i2c_scl_i),
                              .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
    i2c_line_sync u_sda_sync (.clk_i(clk_i), .rst_i(rst_i), .line_i(bus.i2c_sda_i),
                              .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

    assign start_det = scl_lvl & sda_fall;
    assign stop_det  = scl_lvl & sda_rise;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               rw_q, rw_d, sda_t_q, sda_t_d, busy_q, busy_d;
    logic               wr_valid_q, wr_valid_d;
    logic [7:0]         wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic               bus_we;
    logic [7:0]         shifted, rd_byte, usr_rdata_q;
    logic [IDX_W-1:0]   usr_idx;
    logic [7:0]         regs [REG_DEPTH];
    logic               usr_addr_unused;

    assign shifted         = {shift_q[6:0], sda_lvl};
    assign rd_byte         = regs[ptr_q];
    assign usr_idx         = usr_addr_i[IDX_W-1:0];
    assign usr_addr_unused = ^(usr_addr_i >> IDX_W);

    // cnt counts SCL rises in the current byte; 8 and 9 mark the ACK slot phases.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_t_d    = sda_t_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        bus_we     = 1'b0;
        if (stop_det) begin
            state_d = ST_IDLE;
            sda_t_d = 1'b1;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
            sda_t_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'(BYTE_BITS - 1)) begin
                            if (state_q == ST_ADDR) begin
                                if (shifted[7:1] == TARGET_ADDR) begin
                                    state_d = ST_ADDR_ACK;
                                    rw_d    = shifted[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = ST_IGNORE;
                                    busy_d  = 1'b0;
                                end
                            end else if (state_q == ST_PTR) begin
                                state_d = ST_PTR_ACK;
                                ptr_d   = shifted[IDX_W-1:0];
                            end else begin
                                state_d    = ST_WDATA_ACK;
                                bus_we     = 1'b1;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = 8'(ptr_q);
                                wr_data_d  = shifted;
                                ptr_d      = ptr_q + IDX_W'(1);
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        sda_t_d = I2C_ACK;
                    end else if (scl_fall && cnt_q == 4'd9) begin
                        cnt_d   = 4'd0;
                        sda_t_d = 1'b1;
                        if (state_q == ST_ADDR_ACK && rw_q) begin
                            state_d = ST_RDATA;
                            shift_d = rd_byte;
                            sda_t_d = rd_byte[7];
                        end else if (state_q == ST_ADDR_ACK) begin
                            state_d = ST_PTR;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        sda_t_d = 1'b1;
                        state_d = ST_RDATA_MACK;
                    end else if (scl_fall) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        sda_t_d = shift_q[6];
                    end
                end
                ST_RDATA_MACK: begin
                    if (scl_rise) begin
                        cnt_d = 4'd9;
                        if (sda_lvl == I2C_NACK) state_d = ST_IGNORE;
                        else                     ptr_d   = ptr_q + IDX_W'(1);
                    end else if (scl_fall && cnt_q == 4'd9) begin
                        state_d = ST_RDATA;
                        cnt_d   = 4'd0;
                        shift_d = rd_byte;
                        sda_t_d = rd_byte[7];
                    end
                end
                default: sda_t_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_t_q     <= 1'b1;
            busy_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            usr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_t_q     <= sda_t_d;
            busy_q      <= busy_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            usr_rdata_q <= regs[usr_idx];
        end
    end

    // Bus write takes priority over a user write to the same register.
    for (genvar gi = 0; gi < REG_DEPTH; gi++) begin : g_reg
        logic [7:0] reg_q;
        always_ff @(posedge clk_i) begin
            if (rst_i)                                   reg_q <= '0;
            else if (bus_we && ptr_q == IDX_W'(gi))      reg_q <= shifted;
            else if (usr_we_i && usr_idx == IDX_W'(gi))  reg_q <= usr_wdata_i;
        end
        assign regs[gi] = reg_q;
    end

    assign bus.i2c_sda_o = 1'b0;
    assign bus.i2c_sda_t = sda_t_q | rst_i;
    assign usr_rdata_o   = usr_rdata_q;
    assign wr_valid_o    = wr_valid_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bus-level bench: I2C master BFM (SCL = clk/20) against a register-array reference model.
module tb_i2c_target_regfile;
    import i2c_target_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1, m_sda = 1'b1;
    logic usr_we = 1'b0;
    logic [7:0] usr_addr = '0, usr_wdata = '0, usr_rdata;
    logic wr_valid, busy;
    logic [7:0] wr_addr, wr_data;
    int checks = 0, failures = 0;

    logic [7:0]  ref_regs [16];
    logic [15:0] exp_wr[$], obs_wr[$];
    logic [7:0]  txn_data [8];
    logic        addr_seen, sda_low_seen, busy_seen;

    always #5 clk = ~clk;

    i2c_target_regfile_if bus();
    assign bus.i2c_scl_i = m_scl;
    assign bus.i2c_sda_i = m_sda & bus.i2c_sda_t;

    i2c_target_regfile #(.TARGET_ADDR(7'h50), .REG_DEPTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .usr_we_i(usr_we), .usr_addr_i(usr_addr), .usr_wdata_i(usr_wdata),
        .usr_rdata_o(usr_rdata), .wr_valid_o(wr_valid), .wr_addr_o(wr_addr),
        .wr_data_o(wr_data), .busy_o(busy));

    always @(negedge clk) begin
        if (wr_valid === 1'b1) obs_wr.push_back({wr_addr, wr_data});
        if (dut.state_q == ST_ADDR) addr_seen = 1'b1;
        if (bus.i2c_sda_t === 1'b0) sda_low_seen = 1'b1;
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    initial begin
        #(10_000_000);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wclk(5); m_scl = 1'b1; wclk(5);
        m_sda = 1'b0; wclk(5); m_scl = 1'b0; wclk(5);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wclk(5); m_scl = 1'b1; wclk(5); m_sda = 1'b1; wclk(5);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; wclk(5); m_scl = 1'b1; wclk(10); m_scl = 1'b0; wclk(5);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; wclk(5); m_scl = 1'b1; wclk(5);
        b = bus.i2c_sda_i;
        wclk(5); m_scl = 1'b0; wclk(5);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin recv_bit(b); d[i] = b; end
        send_bit(mack);
    endtask

    task automatic check_wr_queue(input string tag);
        chk({tag, "_wr_count"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
            chk({tag, "_wr_pulse"}, 32'(obs_wr[i]), 32'(exp_wr[i]));
        obs_wr.delete();
        exp_wr.delete();
    endtask

    task automatic usr_read(input int a, input string tag);
        usr_addr = 8'(a); wclk(1);
        chk(tag, 32'(usr_rdata), 32'(ref_regs[a % 16]));
    endtask

    task automatic usr_write(input int a, input logic [7:0] d);
        usr_addr = 8'(a); usr_wdata = d; usr_we = 1'b1; wclk(1); usr_we = 1'b0;
        ref_regs[a % 16] = d;
    endtask

    // Expected: matching address ACKs everything; other addresses see only released SDA.
    task automatic do_write(input logic [6:0] a7, input logic [7:0] ptr, input int n, input string tag);
        logic ack;
        int rp;
        logic match;
        match = (a7 == 7'h50);
        sda_low_seen = 1'b0; busy_seen = 1'b0;
        i2c_start();
        write_byte({a7, 1'b0}, ack); chk({tag, "_addr_ack"}, 32'(ack), match ? 32'd0 : 32'd1);
        write_byte(ptr, ack);        chk({tag, "_ptr_ack"}, 32'(ack), match ? 32'd0 : 32'd1);
        rp = ptr % 16;
        for (int k = 0; k < n; k++) begin
            write_byte(txn_data[k], ack);
            chk({tag, "_data_ack"}, 32'(ack), match ? 32'd0 : 32'd1);
            if (match) begin
                ref_regs[rp] = txn_data[k];
                exp_wr.push_back({8'(rp), txn_data[k]});
                rp = (rp + 1) % 16;
            end
        end
        i2c_stop(); wclk(10);
        if (!match) begin
            chk({tag, "_mm_sda_low"}, 32'(sda_low_seen), 32'd0);
            chk({tag, "_mm_busy"}, 32'(busy_seen), 32'd0);
        end
        chk({tag, "_busy_after_stop"}, 32'(busy), 32'd0);
        check_wr_queue(tag);
        $display("TXN %s write addr=%02h ptr=%02h n=%0d", tag, a7, ptr, n);
    endtask

    task automatic do_read(input logic [7:0] ptr, input int n, input string tag);
        logic ack;
        logic [7:0] b;
        int rp;
        i2c_start();
        write_byte(8'hA0, ack); chk({tag, "_addr_ack"}, 32'(ack), 32'd0);
        write_byte(ptr, ack);   chk({tag, "_ptr_ack"}, 32'(ack), 32'd0);
        i2c_start();
        write_byte(8'hA1, ack); chk({tag, "_raddr_ack"}, 32'(ack), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        rp = ptr % 16;
        for (int k = 0; k < n; k++) begin
            read_byte(b, (k == n - 1) ? 1'b1 : 1'b0);
            chk({tag, "_rdata"}, 32'(b), 32'(ref_regs[rp]));
            rp = (rp + 1) % 16;
        end
        chk({tag, "_released_after_nack"}, 32'(bus.i2c_sda_t), 32'd1);
        i2c_stop(); wclk(10);
        check_wr_queue(tag);
        $display("TXN %s read ptr=%02h n=%0d", tag, ptr, n);
    endtask

    task automatic do_collision(input logic same, input string tag);
        int other;
        other = same ? 9 : 12;
        txn_data[0] = 8'hC3;
        fork
            do_write(7'h50, 8'h09, 1, tag);
            begin
                for (int k = 0; k < 3000 && dut.bus_we !== 1'b1; k++) @(negedge clk);
                chk({tag, "_bus_we_seen"}, 32'(dut.bus_we), 32'd1);
                usr_addr = 8'(other); usr_wdata = 8'h77; usr_we = 1'b1;
                @(posedge clk); #1 usr_we = 1'b0;
            end
        join
        if (!same) ref_regs[other] = 8'h77;
        usr_read(9, {tag, "_reg9"});
        usr_read(other, {tag, "_other"});
    endtask

    initial begin
        logic ack;
        for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
        wclk(4); rst = 1'b0; wclk(1);
        chk("rst_sda_t", 32'(bus.i2c_sda_t), 32'd1);
        chk("rst_sda_o", 32'(bus.i2c_sda_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_usr_rdata", 32'(usr_rdata), 32'd0);
        for (int i = 0; i < 16; i++) usr_read(i, "rst_reg");
        $display("TXN reset done");

        txn_data[0] = 8'hA5; txn_data[1] = 8'h5A;
        do_write(7'h50, 8'h02, 2, "dir_write");
        usr_read(2, "dir_reg2"); usr_read(3, "dir_reg3");
        do_read(8'h03, 2, "dir_read");

        txn_data[0] = 8'hEE;
        do_write(7'h51, 8'h04, 1, "mismatch");
        usr_read(4, "mm_reg4");

        txn_data[0] = 8'h11; txn_data[1] = 8'h22;
        do_write(7'h50, 8'h0F, 2, "wrap");
        usr_read(15, "wrap_reg15"); usr_read(0, "wrap_reg0");
        do_read(8'h0F, 2, "wrap_read");

        // Abort: STOP after 4 data bits discards the partial byte.
        i2c_start();
        write_byte(8'hA0, ack); write_byte(8'h05, ack);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_stop(); wclk(10);
        chk("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
        check_wr_queue("abort");
        usr_read(5, "abort_reg5");
        $display("TXN abort after 4 bits");

        do_collision(1'b1, "coll_same");
        do_collision(1'b0, "coll_diff");

        for (int t = 0; t < 12; t++) begin
            int op, n;
            logic [6:0] a7;
            op = $urandom_range(0, 2);
            n  = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) txn_data[k] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) usr_write($urandom_range(0, 15), 8'($urandom));
            if (op == 0) begin
                do_write(7'h50, 8'($urandom), n, "rnd_write");
            end else if (op == 1) begin
                do_read(8'($urandom), n, "rnd_read");
            end else begin
                a7 = 7'($urandom);
                if (a7 == 7'h50) a7 = 7'h51;
                do_write(a7, 8'($urandom), n, "rnd_mismatch");
            end
            usr_read($urandom_range(0, 15), "rnd_usr");
        end

        // Reset while the target is driving a 0 read bit.
        usr_write(7, 8'h3C);
        i2c_start();
        write_byte(8'hA0, ack); write_byte(8'h07, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        chk("rstrd_driving", 32'(bus.i2c_sda_t), 32'd0);
        rst = 1'b1; wclk(1);
        chk("rstrd_released", 32'(bus.i2c_sda_t), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
        m_scl = 1'b1; wclk(5); m_sda = 1'b1; wclk(10);
        usr_read(7, "rstrd_reg7"); usr_read(2, "rstrd_reg2");
        chk("rstrd_busy", 32'(busy), 32'd0);
        obs_wr.delete(); exp_wr.delete();
        $display("TXN reset during read");

        // One-clock SDA low glitch while SCL is high.
        addr_seen = 1'b0;
        m_sda = 1'b0; wclk(1); m_sda = 1'b1; wclk(12);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        chk("glitch_start", 32'(addr_seen), 32'd0);
`else
        chk("glitch_start", 32'(addr_seen), 32'd1);
`endif
        chk("glitch_busy", 32'(busy), 32'd0);
        $display("TXN sda glitch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
